// File: rtl/ahb_arbiter.sv
// AHB round-robin bus arbiter (PARK/OWN/LOCKED). Lock support is compiled in by AHB_ARB_LOCK_EN.
// Grant moves on hready=1 edges, hmaster/hmastlock follow one hready edge later; hready=0 freezes all state.
`timescale 1ns/1ps
module ahb_arbiter #(
    parameter int DEFAULT_MST = 0,
    parameter int MAX_BEATS   = 16
) (
    input  logic       hclk,
    input  logic       hreset,
    input  logic [3:0] hbusreq,
    input  logic [3:0] hlock,
    input  logic [1:0] htrans,
    input  logic [2:0] hburst,
    input  logic       hready,
    output logic [3:0] hgrant,
    output logic [1:0] hmaster,
    output logic       hmastlock
);

    localparam logic [1:0] DEF_IDX  = 2'(DEFAULT_MST);
    localparam logic [7:0] INCR_LEN = 8'(MAX_BEATS);
    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    typedef enum logic [1:0] {PARK, OWN, LOCKED} state_t;

    state_t     state_q, state_d;
    logic [1:0] grant_q, grant_d;
    logic [1:0] hmaster_q, hmaster_d;
    logic       mastlock_q, mastlock_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] rr_q, rr_d;

    logic [3:0] lock_req;
    logic [7:0] tenure_len;
    logic [7:0] cnt_next;
    logic       final_beat;
    logic       owner_on_bus;
    logic       rearb_own;
    logic       do_arb;
    logic [2:0] pick;

`ifdef AHB_ARB_LOCK_EN
    assign lock_req = hlock;
`else
    logic unused_hlock;
    assign unused_hlock = ^hlock;
    assign lock_req     = 4'b0000;
`endif

    // Round-robin search from ptr+1, wrapping back to ptr itself last; msb = any request found.
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [2:0] res;
        logic [1:0] idx;
        res = {1'b0, ptr};
        for (int i = 4; i >= 1; i--) begin
            idx = ptr + 2'(i);
            if (req[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q    <= PARK;
            grant_q    <= DEF_IDX;
            hmaster_q  <= DEF_IDX;
            mastlock_q <= 1'b0;
            cnt_q      <= 8'd0;
            rr_q       <= DEF_IDX;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            hmaster_q  <= hmaster_d;
            mastlock_q <= mastlock_d;
            cnt_q      <= cnt_d;
            rr_q       <= rr_d;
        end
    end

    always_comb begin
        case (hburst)
            3'b000:          tenure_len = 8'd1;
            3'b001:          tenure_len = INCR_LEN;
            3'b010, 3'b011:  tenure_len = 8'd4;
            3'b100, 3'b101:  tenure_len = 8'd8;
            default:         tenure_len = 8'd16;
        endcase
    end

    always_comb begin
        cnt_next = cnt_q;
        if (htrans == TR_NONSEQ)
            cnt_next = 8'd1;
        else if (htrans == TR_SEQ && cnt_q != 8'hFF)
            cnt_next = cnt_q + 8'd1;
    end

    // Burst-based triggers only apply once the granted master actually drives the address phase.
    assign final_beat   = htrans[1] && (cnt_next >= tenure_len);
    assign owner_on_bus = (hmaster_q == grant_q);
    assign rearb_own    = !hbusreq[grant_q] || (owner_on_bus && (htrans == TR_IDLE || final_beat));
    assign pick         = rr_pick(hbusreq, rr_q);

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        hmaster_d  = hmaster_q;
        mastlock_d = mastlock_q;
        cnt_d      = cnt_q;
        rr_d       = rr_q;
        do_arb     = 1'b0;
        if (hready) begin
            cnt_d      = cnt_next;
            hmaster_d  = grant_q;
            mastlock_d = (state_q == LOCKED);
            case (state_q)
                PARK:    do_arb = |hbusreq;
                OWN:     do_arb = rearb_own;
                LOCKED:  do_arb = !lock_req[grant_q];
                default: do_arb = 1'b1;
            endcase
            if (do_arb) begin
                if (pick[2]) begin
                    grant_d = pick[1:0];
                    rr_d    = pick[1:0];
                    state_d = lock_req[pick[1:0]] ? LOCKED : OWN;
                end else begin
                    grant_d = DEF_IDX;
                    state_d = PARK;
                end
            end
        end
    end

    always_comb begin
        hgrant  = 4'b0001 << grant_q;
        hmaster = hmaster_q;
`ifdef AHB_ARB_LOCK_EN
        hmastlock = mastlock_q;
`else
        hmastlock = 1'b0;
`endif
    end

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed self-checking bench for ahb_arbiter (DEFAULT_MST=0, MAX_BEATS=16).
`timescale 1ns/1ps
module tb_ahb_arbiter;

    logic       hclk = 1'b0;
    logic       hreset;
    logic [3:0] hbusreq;
    logic [3:0] hlock;
    logic [1:0] htrans;
    logic [2:0] hburst;
    logic       hready;
    logic [3:0] hgrant;
    logic [1:0] hmaster;
    logic       hmastlock;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] IDLE = 2'b00, NONSEQ = 2'b10, SEQ = 2'b11;
    localparam logic [2:0] SINGLE = 3'b000, INCR = 3'b001, INCR4 = 3'b011, INCR8 = 3'b101;

    ahb_arbiter #(.DEFAULT_MST(0), .MAX_BEATS(16)) dut (
        .hclk      (hclk),
        .hreset    (hreset),
        .hbusreq   (hbusreq),
        .hlock     (hlock),
        .htrans    (htrans),
        .hburst    (hburst),
        .hready    (hready),
        .hgrant    (hgrant),
        .hmaster   (hmaster),
        .hmastlock (hmastlock)
    );

    always #5 hclk = ~hclk;

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic apply_reset();
        hreset  = 1'b1;
        hbusreq = 4'b0000;
        hlock   = 4'b0000;
        htrans  = IDLE;
        hburst  = SINGLE;
        hready  = 1'b1;
        step();
        hreset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (hgrant !== 4'b0001 || hmaster !== 2'd0 || hmastlock !== 1'b0) begin
                errors++;
                $display("FAIL reset_park cyc%0d: hgrant=%b hmaster=%0d hmastlock=%b, want 0001/0/0", i, hgrant, hmaster, hmastlock);
            end
            step();
        end
    endtask

    task automatic test_rr_single();
        logic [3:0] exp_g [8] = '{4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0001};
        logic [1:0] exp_m [8] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
        apply_reset();
        hbusreq = 4'b1111;
        htrans  = NONSEQ;
        hburst  = SINGLE;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (hgrant !== exp_g[i] || hmaster !== exp_m[i]) begin
                errors++;
                $display("FAIL rr_single edge%0d: hgrant=%b hmaster=%0d, want %b/%0d", i + 1, hgrant, hmaster, exp_g[i], exp_m[i]);
            end
        end
    endtask

    task automatic test_park_hready_hold();
        apply_reset();
        hbusreq = 4'b0100;
        hready  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (hgrant !== 4'b0001) begin
                errors++;
                $display("FAIL park_hold cyc%0d: hgrant=%b, want 0001", i, hgrant);
            end
        end
        hready = 1'b1;
        step();
        checks++;
        if (hgrant !== 4'b0100 || hmaster !== 2'd0) begin
            errors++;
            $display("FAIL park_to_own: hgrant=%b hmaster=%0d, want 0100/0", hgrant, hmaster);
        end
    endtask

    task automatic test_same_owner();
        apply_reset();
        hbusreq = 4'b0100;
        htrans  = NONSEQ;
        hburst  = SINGLE;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (hgrant !== 4'b0100) begin
                errors++;
                $display("FAIL same_owner edge%0d: hgrant=%b, want 0100", i + 1, hgrant);
            end
        end
    endtask

    task automatic test_incr8_wait();
        apply_reset();
        hbusreq = 4'b0010;
        step();
        step();
        checks++;
        if (hgrant !== 4'b0010 || hmaster !== 2'd1) begin
            errors++;
            $display("FAIL incr8_own: hgrant=%b hmaster=%0d, want 0010/1", hgrant, hmaster);
        end
        hburst = INCR8;
        for (int beat = 1; beat <= 8; beat++) begin
            htrans = (beat == 1) ? NONSEQ : SEQ;
            if (beat == 3) hbusreq = 4'b0110;
            if (beat == 5) begin
                hready = 1'b0;
                for (int w = 0; w < 2; w++) begin
                    step();
                    checks++;
                    if (hgrant !== 4'b0010 || hmaster !== 2'd1) begin
                        errors++;
                        $display("FAIL incr8_wait w%0d: hgrant=%b hmaster=%0d, want 0010/1", w, hgrant, hmaster);
                    end
                end
                hready = 1'b1;
            end
            step();
            checks++;
            if (hgrant !== ((beat == 8) ? 4'b0100 : 4'b0010)) begin
                errors++;
                $display("FAIL incr8_beat%0d: hgrant=%b, want %b", beat, hgrant, (beat == 8) ? 4'b0100 : 4'b0010);
            end
        end
        htrans = IDLE;
        step();
        checks++;
        if (hmaster !== 2'd2 || hgrant !== 4'b0100) begin
            errors++;
            $display("FAIL incr8_handover: hmaster=%0d hgrant=%b, want 2/0100", hmaster, hgrant);
        end
    endtask

    task automatic test_incr_cap();
        apply_reset();
        hbusreq = 4'b0001;
        step();
        hbusreq = 4'b1001;
        hburst  = INCR;
        for (int beat = 1; beat <= 16; beat++) begin
            htrans = (beat == 1) ? NONSEQ : SEQ;
            step();
            checks++;
            if (hgrant !== ((beat == 16) ? 4'b1000 : 4'b0001)) begin
                errors++;
                $display("FAIL incr_cap beat%0d: hgrant=%b, want %b", beat, hgrant, (beat == 16) ? 4'b1000 : 4'b0001);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        apply_reset();
        hbusreq = 4'b1000;
        step();
        step();
        hburst = INCR4;
        htrans = NONSEQ;
        step();
        htrans = SEQ;
        step();
        checks++;
        if (hgrant !== 4'b1000 || hmaster !== 2'd3) begin
            errors++;
            $display("FAIL mid_burst_owner: hgrant=%b hmaster=%0d, want 1000/3", hgrant, hmaster);
        end
        #2;
        hreset = 1'b1;
        #1;
        checks++;
        if (hgrant !== 4'b0001 || hmaster !== 2'd0 || hmastlock !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: hgrant=%b hmaster=%0d hmastlock=%b, want 0001/0/0", hgrant, hmaster, hmastlock);
        end
        step();
        hreset  = 1'b0;
        hbusreq = 4'b1111;
        htrans  = IDLE;
        step();
        checks++;
        if (hgrant !== 4'b0010) begin
            errors++;
            $display("FAIL post_reset_rr: hgrant=%b, want 0010", hgrant);
        end
    endtask

`ifdef AHB_ARB_LOCK_EN
    task automatic test_lock();
        apply_reset();
        hbusreq = 4'b0100;
        hlock   = 4'b0100;
        step();
        step();
        hbusreq = 4'b1111;
        hburst  = INCR;
        for (int beat = 1; beat <= 20; beat++) begin
            htrans = (beat == 1) ? NONSEQ : SEQ;
            step();
            checks++;
            if (hgrant !== 4'b0100 || hmastlock !== 1'b1) begin
                errors++;
                $display("FAIL lock_hold beat%0d: hgrant=%b hmastlock=%b, want 0100/1", beat, hgrant, hmastlock);
            end
        end
        hlock = 4'b0000;
        step();
        checks++;
        if (hgrant !== 4'b1000) begin
            errors++;
            $display("FAIL lock_release: hgrant=%b, want 1000", hgrant);
        end
        htrans = IDLE;
        step();
        checks++;
        if (hmastlock !== 1'b0 || hmaster !== 2'd3) begin
            errors++;
            $display("FAIL lock_drop: hmastlock=%b hmaster=%0d, want 0/3", hmastlock, hmaster);
        end
    endtask
`else
    task automatic test_lock();
        apply_reset();
        hbusreq = 4'b0010;
        hlock   = 4'b1111;
        htrans  = NONSEQ;
        hburst  = SINGLE;
        step();
        step();
        checks++;
        if (hmastlock !== 1'b0 || hgrant !== 4'b0010) begin
            errors++;
            $display("FAIL lock_ignored: hmastlock=%b hgrant=%b, want 0/0010", hmastlock, hgrant);
        end
        hbusreq = 4'b0110;
        step();
        checks++;
        if (hgrant !== 4'b0100 || hmastlock !== 1'b0) begin
            errors++;
            $display("FAIL lock_not_held: hgrant=%b hmastlock=%b, want 0100/0", hgrant, hmastlock);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_rr_single();
        test_park_hready_hold();
        test_same_owner();
        test_incr8_wait();
        test_incr_cap();
        test_reset_mid_burst();
        test_lock();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_arbiter.md
AHB_ARBITER -- requirements
Module: ahb_arbiter

Interface
REQ-001 SHALL provide parameter DEFAULT_MST, default 0, meaning the master index (0-3) granted when no hbusreq is asserted.
REQ-002 SHALL provide parameter MAX_BEATS, default 16, meaning the INCR (undefined-length) tenure cap in beats (range 2-255).
REQ-003 SHALL provide port hclk  input  1  bus clock; all state on rising edge.
REQ-004 SHALL provide port hreset  input  1  asynchronous, active-high reset.
REQ-005 SHALL provide port hbusreq  input  4  per-master bus request, bit i = master i.
REQ-006 SHALL provide port hlock  input  4  per-master locked-sequence request.
REQ-007 SHALL provide port htrans  input  2  transfer type of current address-phase owner (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
REQ-008 SHALL provide port hburst  input  3  burst type of current address-phase owner.
REQ-009 SHALL provide port hready  input  1  muxed slave ready (hreadyout path).
REQ-010 SHALL provide port hgrant  output  4  one-hot grant.
REQ-011 SHALL provide port hmaster  output  2  index of master owning the address phase.
REQ-012 SHALL provide port hmastlock  output  1  current address-phase transfer is locked.

Function
REQ-013 hgrant SHALL be one-hot at all times; exactly one bit set, including when no master requests.
REQ-014 FSM SHALL have states PARK (no request, DEFAULT_MST granted), OWN (granted master in tenure), LOCKED (locked tenure).
REQ-015 Arbitration SHALL be round-robin: search starts at (last owner + 1) mod 4, wrapping, first asserted hbusreq wins.
REQ-016 Grant SHALL change only on a rising edge with hready=1; with hready=0 hgrant, hmaster, counter, and state SHALL hold.
REQ-017 hmaster and hmastlock SHALL update on the hready=1 edge following the hgrant change (one-cycle address-phase lag).
REQ-018 Beat counter SHALL increment on each edge with hready=1 and htrans NONSEQ/SEQ, reload to 1 on NONSEQ, hold on BUSY/IDLE.
REQ-019 Tenure length SHALL be: SINGLE 1; INCR4/WRAP4 4; INCR8/WRAP8 8; INCR16/WRAP16 16; INCR MAX_BEATS.
REQ-020 In OWN, re-arbitration SHALL occur when the owner deasserts hbusreq, htrans=IDLE, or the counter reaches tenure length on the final beat; grant SHALL not change mid-fixed-burst.
REQ-021 When re-arbitration finds only the current owner requesting, grant SHALL remain; counter restarts at next NONSEQ.
REQ-022 PARK->OWN SHALL occur on the first hready=1 edge with any hbusreq set; OWN->PARK when hbusreq=0000 at a re-arbitration point, with hgrant=DEFAULT_MST.
REQ-023 Simultaneous requests SHALL resolve purely by round-robin order, no fixed priority.

Reset
REQ-024 While hreset=1, immediately and independent of hclk: state PARK, hgrant one-hot DEFAULT_MST, hmaster=DEFAULT_MST, hmastlock=0, counter 0, RR pointer DEFAULT_MST.
REQ-025 Reset mid-burst SHALL abandon the tenure; first post-reset arbitration starts from DEFAULT_MST+1.

Configuration
REQ-026 Macro AHB_ARB_LOCK_EN SHALL compile in lock support: granting a master with hlock=1 enters LOCKED; grant held until owner hlock=0 and current transfer completes with hready=1, ignoring tenure limit and other requests; hmastlock mirrors owner hlock with REQ-017 timing.
REQ-027 Without AHB_ARB_LOCK_EN, hlock SHALL be ignored, LOCKED unreachable, hmastlock tied 0.

Verification
REQ-028 Reset, hbusreq=0000, DEFAULT_MST=0 -> hgrant=0001, hmaster=0, hmastlock=0 with hready=1 throughout.
REQ-029 hbusreq=1111 held, all masters SINGLE, hready=1 -> hgrant sequence 0010,0100,1000,0001, one change per transfer.
REQ-030 Master 1 INCR8, master 2 requests at beat 3, hready low 2 cycles at beat 5 -> hgrant stays 0010 until beat 8 completes, then 0100; hmaster=2 one hready edge later.
REQ-031 Master 0 INCR, MAX_BEATS=16, master 3 requesting -> hgrant moves to 1000 after 16th beat.
REQ-032 AHB_ARB_LOCK_EN, master 2 hlock=1 for 20 beats, all others requesting -> hgrant=0100 and hmastlock=1 throughout; release one transfer after hlock=0.
REQ-033 hreset pulsed mid-INCR4 of master 3 -> hgrant=0001 asynchronously; next grant with hbusreq=1111 goes to master 1.
